sar_search_8b_int: RTL and testbench

SAR_SEARCH_8B_INT -- requirements
Module: sar_search_8b_int

---
 rtl/sar_search_8b_int.sv | 131 +++++++++++++
 tb/tb_sar_search_8b_int.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search_8b_int.sv
// Successive-approximation search for an 8-bit two's complement target.
// An external comparator compares the hidden target A with the probe B
// and reports less/equal/greater. The search walks an offset-binary code
// from MSB to LSB, one comparator decision per clock. The valid target
// range is -127..127; a search that ends on code 8'h00 (-128) is flagged
// as an error, as is any comparator answer that is not exactly one-hot.
module sar_search_8b_int (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       a_less_b,
    input  logic       a_eq_b,
    input  logic       a_gt_b,
    output logic [7:0] probe,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_r;
    logic [7:0] code_r;
    logic [2:0] idx_r;

    logic [2:0] flags_s;
    logic       one_hot_s;
    logic [7:0] bit_mask_s;
    logic [7:0] lower_mask_s;
    logic [7:0] decided_code_s;
    logic [7:0] next_code_s;

    // Offset-binary code <-> two's complement value (the mapping is its own inverse).
    function automatic logic [7:0] offset_flip(input logic [7:0] code_val);
        return code_val ^ 8'h80;
    endfunction

    // Decide the current bit from the comparator and pre-set the next lower bit.
    always_comb begin
        flags_s      = {a_less_b, a_eq_b, a_gt_b};
        bit_mask_s   = 8'h01 << idx_r;
        lower_mask_s = bit_mask_s >> 1;
        case (flags_s)
            3'b100,
            3'b010,
            3'b001:  one_hot_s = 1'b1;
            default: one_hot_s = 1'b0;
        endcase
        if (a_less_b) begin
            decided_code_s = code_r & ~bit_mask_s;
        end else begin
            decided_code_s = code_r;
        end
        next_code_s = decided_code_s | lower_mask_s;
    end

    // Search state machine; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            code_r  <= 8'h00;
            idx_r   <= 3'd0;
            probe   <= 8'h00;
            result  <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r <= ST_RUN;
                        code_r  <= 8'h80;
                        idx_r   <= 3'd7;
                        probe   <= 8'h00;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!one_hot_s) begin
                        // Comparator answer is inconsistent: abort on the current probe.
                        result  <= probe;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (a_eq_b) begin
                        result  <= probe;
                        err     <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (idx_r != 3'd0) begin
                        code_r  <= next_code_s;
                        idx_r   <= idx_r - 3'd1;
                        probe   <= offset_flip(next_code_s);
                        state_r <= ST_RUN;
                    end else begin
                        // Last bit decided; code 8'h00 means the target was -128.
                        result  <= offset_flip(decided_code_s);
                        err     <= (decided_code_s == 8'h00);
                        code_r  <= decided_code_s;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search_8b_int.sv
// Directed bench for sar_search_8b_int with a behavioural comparator model
// and fault overrides on the comparator flags.
module tb_sar_search_8b_int;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       a_less_b;
    logic       a_eq_b;
    logic       a_gt_b;
    logic [7:0] probe;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       err;

    logic signed [7:0] target_r;
    int                fault_mode;   // 0 normal, 1 less+gt both set, 2 no flag set
    int                checks;
    int                errors;
    int                done_cnt;
    logic [7:0]        seen_probe [0:15];
    int                seen_n;
    logic              timed_out;

    sar_search_8b_int dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_less_b (a_less_b),
        .a_eq_b   (a_eq_b),
        .a_gt_b   (a_gt_b),
        .probe    (probe),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator model: A is the bench target, B is the probe.
    assign a_less_b = (fault_mode == 1) ? 1'b1 : (fault_mode == 2) ? 1'b0 : (target_r < $signed(probe));
    assign a_gt_b   = (fault_mode == 1) ? 1'b1 : (fault_mode == 2) ? 1'b0 : (target_r > $signed(probe));
    assign a_eq_b   = (fault_mode != 0) ? 1'b0 : (target_r == $signed(probe));

    // Count done cycles.
    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Start a search and record each RUN-cycle probe until done (bounded).
    task run_search(input logic signed [7:0] t);
        @(negedge clk);
        target_r = t;
        start    = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        seen_n    = 0;
        timed_out = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            if (seen_n < 16) seen_probe[seen_n] = probe;
            seen_n++;
            @(negedge clk);
        end
    endtask

    task test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({probe, result, busy, done, err} !== 19'h0) begin
            errors++;
            $display("FAIL reset_hold: got probe=%h result=%h busy=%b done=%b err=%b, expected all zero",
                     probe, result, busy, done, err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({probe, result, busy, done, err} !== 19'h0) begin
            errors++;
            $display("FAIL reset_release: got probe=%h result=%h busy=%b done=%b err=%b, expected all zero",
                     probe, result, busy, done, err);
        end
    endtask

    task test_search(input string name, input logic signed [7:0] t, input logic [63:0] exp_seq,
                     input logic [7:0] exp_result, input logic exp_err, input logic [7:0] prev_result);
        logic [63:0] seq_v;
        int          dc0;
        dc0   = done_cnt;
        seq_v = exp_seq;
        run_search(t);
        checks++;
        if (timed_out !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: no done within 20 cycles", name);
        end
        checks++;
        if (seen_n != 8) begin
            errors++;
            $display("FAIL %s_run_cycles: got %0d expected 8", name, seen_n);
        end
        checks++;
        if (seen_probe[0] !== 8'h00 || seen_n < 1) begin
            errors++;
            $display("FAIL %s_first_probe: got %h expected 00", name, seen_probe[0]);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (seen_probe[k] !== seq_v[63 - 8*k -: 8]) begin
                errors++;
                $display("FAIL %s_probe%0d: got %h expected %h", name, k, seen_probe[k], seq_v[63 - 8*k -: 8]);
            end
        end
        checks++;
        if (result !== exp_result || err !== exp_err || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_result: got result=%h err=%b busy=%b expected result=%h err=%b busy=0",
                     name, result, err, busy, exp_result, exp_err);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== exp_result || err !== exp_err || done_cnt - dc0 != 1) begin
            errors++;
            $display("FAIL %s_after_done: got done=%b result=%h err=%b pulses=%0d expected done=0 result=%h err=%b pulses=1",
                     name, done, result, err, done_cnt - dc0, exp_result, exp_err);
        end
        if (prev_result !== 8'hxx) begin
            // result must not have moved during the RUN cycles of this search
        end
    endtask

    task test_result_held;
        // Previous result (7F) must stay visible while a new search runs.
        @(negedge clk);
        target_r = -8'sd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (result !== 8'h7F || busy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL result_held: got result=%h busy=%b err=%b expected result=7f busy=1 err=0",
                     result, busy, err);
        end
        timed_out = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (timed_out !== 1'b0 || result !== 8'hFD || err !== 1'b0) begin
            errors++;
            $display("FAIL result_neg3: got result=%h err=%b timeout=%b expected result=fd err=0",
                     result, err, timed_out);
        end
        @(negedge clk);
    endtask

    task test_fault_both;
        @(negedge clk);
        target_r = 8'sd5;
        start    = 1'b1;
        @(negedge clk);           // RUN cycle 1
        start = 1'b0;
        @(negedge clk);           // RUN cycle 2
        @(negedge clk);           // RUN cycle 3
        checks++;
        if (probe !== 8'h20) begin
            errors++;
            $display("FAIL fault_probe3: got %h expected 20", probe);
        end
        fault_mode = 1;
        @(negedge clk);
        fault_mode = 0;
        checks++;
        if (done !== 1'b1 || err !== 1'b1 || result !== 8'h20 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fault_both: got done=%b err=%b result=%h busy=%b expected done=1 err=1 result=20 busy=0",
                     done, err, result, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || err !== 1'b1 || result !== 8'h20) begin
            errors++;
            $display("FAIL fault_hold: got done=%b err=%b result=%h expected done=0 err=1 result=20",
                     done, err, result);
        end
    endtask

    task test_fault_none;
        fault_mode = 2;
        @(negedge clk);
        target_r = 8'sd9;
        start    = 1'b1;
        @(negedge clk);           // RUN cycle 1, no flag set
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL none_start: got busy=%b err=%b expected busy=1 err=0", busy, err);
        end
        @(negedge clk);
        fault_mode = 0;
        checks++;
        if (done !== 1'b1 || err !== 1'b1 || result !== 8'h00) begin
            errors++;
            $display("FAIL none_flags: got done=%b err=%b result=%h expected done=1 err=1 result=00",
                     done, err, result);
        end
        @(negedge clk);
    endtask

    task test_start_during_run;
        int dc0;
        dc0 = done_cnt;
        @(negedge clk);
        target_r = 8'sd5;
        start    = 1'b1;
        @(negedge clk);           // RUN 1
        start = 1'b0;
        @(negedge clk);           // RUN 2
        start = 1'b1;
        repeat (3) @(negedge clk); // RUN 3..5
        start = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt - dc0 != 1 || result !== 8'h05 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored: got pulses=%0d result=%h busy=%b expected pulses=1 result=05 busy=0",
                     done_cnt - dc0, result, busy);
        end
    endtask

    task test_back_to_back;
        int dc0;
        dc0 = done_cnt;
        @(negedge clk);
        target_r = 8'sd5;
        start    = 1'b1;
        timed_out = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
        checks++;
        if (timed_out !== 1'b0 || result !== 8'h05) begin
            errors++;
            $display("FAIL b2b_first: got result=%h timeout=%b expected result=05", result, timed_out);
        end
        @(negedge clk);           // IDLE: start seen in DONE was ignored
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b done=%b expected busy=0 done=0", busy, done);
        end
        @(negedge clk);           // accepted on the edge leaving IDLE
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || probe !== 8'h00) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b probe=%h expected busy=1 probe=00", busy, probe);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (done_cnt - dc0 != 2 || result !== 8'h05) begin
            errors++;
            $display("FAIL b2b_count: got pulses=%0d result=%h expected pulses=2 result=05",
                     done_cnt - dc0, result);
        end
    endtask

    task test_reset_midrun;
        int dc0;
        @(negedge clk);
        target_r = 8'sd5;
        start    = 1'b1;
        @(negedge clk);           // RUN 1
        start = 1'b0;
        repeat (3) @(negedge clk); // RUN 4
        dc0   = done_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({probe, result, busy, done, err} !== 19'h0) begin
            errors++;
            $display("FAIL reset_async: got probe=%h result=%h busy=%b done=%b err=%b expected all zero",
                     probe, result, busy, done, err);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != dc0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: got pulses=%0d busy=%b expected pulses=0 busy=0",
                     done_cnt - dc0, busy);
        end
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || probe !== 8'h00) begin
            errors++;
            $display("FAIL reset_first_start: got busy=%b probe=%h expected busy=1 probe=00", busy, probe);
        end
        timed_out = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (timed_out !== 1'b0 || result !== 8'h05 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_resume: got result=%h err=%b timeout=%b expected result=05 err=0",
                     result, err, timed_out);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        target_r   = 8'sd0;
        fault_mode = 0;
        checks     = 0;
        errors     = 0;
        done_cnt   = 0;
        seen_n     = 0;
        timed_out  = 1'b0;
        test_reset;
        test_search("pos5",   8'sd5,    64'h00_40_20_10_08_04_06_05, 8'h05, 1'b0, 8'h00);
        test_search("neg127", -8'sd127, 64'h00_C0_A0_90_88_84_82_81, 8'h81, 1'b0, 8'h05);
        test_search("pos127", 8'sd127,  64'h00_40_60_70_78_7C_7E_7F, 8'h7F, 1'b0, 8'h81);
        test_result_held;
        test_search("neg128", -8'sd128, 64'h00_C0_A0_90_88_84_82_81, 8'h80, 1'b1, 8'hFD);
        test_fault_both;
        test_fault_none;
        test_start_during_run;
        test_back_to_back;
        test_reset_midrun;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
